freq_to_phase_inc: RTL and testbench

//  Converts a transmit/receive frequency in Hz (from the C&C decoder) into the

---
 rtl/freq_to_phase_inc.sv | 116 +++++++++++
 tb/tb_freq_to_phase_inc.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/freq_to_phase_inc.sv
// rtl/freq_to_phase_inc.sv - Hz to phase-accumulator tuning word via iterative restoring divider
module freq_to_phase_inc #(
  parameter int unsigned CLK_HZ     = 122880000,
  parameter int unsigned RESOLUTION = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           freq_hz,
  input  logic                  freq_valid,
  output logic                  freq_ready,
  output logic [RESOLUTION-1:0] frequency,
  output logic                  freq_update,
  output logic                  range_err
);

  localparam int CNT_W = (RESOLUTION > 1) ? $clog2(RESOLUTION) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESOLUTION - 1);
  // Divisor and Nyquist limit widened to the 33-bit remainder datapath.
  localparam logic [32:0] CLK_W = 33'(CLK_HZ);
  localparam logic [32:0] NYQ_W = 33'(CLK_HZ / 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [32:0]             r_q, r_d;
  logic [RESOLUTION-1:0]   q_q, q_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [RESOLUTION-1:0]   frequency_q, frequency_d;
  logic                    freq_update_q, freq_update_d;
  logic                    range_err_q, range_err_d;

  // Remainder doubled: the trial dividend in DIV, the half-LSB test in ROUND.
  // R < CLK_HZ < 2^32 always, so the shifted value fits in 33 bits.
  logic [32:0] t_w;
  logic        round_up;
  assign t_w      = {r_q[31:0], 1'b0};
  assign round_up = (t_w >= CLK_W);

  // State register and datapath flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      r_q           <= '0;
      q_q           <= '0;
      cnt_q         <= '0;
      frequency_q   <= '0;
      freq_update_q <= 1'b0;
      range_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      r_q           <= r_d;
      q_q           <= q_d;
      cnt_q         <= cnt_d;
      frequency_q   <= frequency_d;
      freq_update_q <= freq_update_d;
      range_err_q   <= range_err_d;
    end
  end

  // Next-state: accept/reject in IDLE, one quotient bit per DIV cycle, round half up.
  always_comb begin
    state_d       = state_q;
    r_d           = r_q;
    q_d           = q_q;
    cnt_d         = cnt_q;
    frequency_d   = frequency_q;
    freq_update_d = 1'b0;
    range_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (freq_valid) begin
          if ({1'b0, freq_hz} >= NYQ_W) begin
            range_err_d = 1'b1;
          end else begin
            r_d     = {1'b0, freq_hz};
            q_d     = '0;
            cnt_d   = '0;
            state_d = DIV;
          end
        end
      end
      DIV: begin
        if (t_w >= CLK_W) begin
          r_d = t_w - CLK_W;
          q_d = {q_q[RESOLUTION-2:0], 1'b1};
        end else begin
          r_d = t_w;
          q_d = {q_q[RESOLUTION-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        // In-range input keeps Q below 2^(RES-1), so this add cannot wrap.
        frequency_d   = q_q + {{(RESOLUTION-1){1'b0}}, round_up};
        freq_update_d = 1'b1;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign freq_ready  = (state_q == IDLE);
  assign frequency   = frequency_q;
  assign freq_update = freq_update_q;
  assign range_err   = range_err_q;

endmodule

// File: tb/tb_freq_to_phase_inc.sv
// tb/tb_freq_to_phase_inc.sv - scoreboard bench for freq_to_phase_inc
module tb_freq_to_phase_inc;

  localparam int unsigned CLK_HZ = 122880000;
  localparam int unsigned RES    = 32;
  localparam int unsigned NYQ    = CLK_HZ / 2;

  logic           clk;
  logic           reset;
  logic [31:0]    freq_hz;
  logic           freq_valid;
  logic           freq_ready;
  logic [RES-1:0] frequency;
  logic           freq_update;
  logic           range_err;

  freq_to_phase_inc #(.CLK_HZ(CLK_HZ), .RESOLUTION(RES)) dut (
    .clk        (clk),
    .reset      (reset),
    .freq_hz    (freq_hz),
    .freq_valid (freq_valid),
    .freq_ready (freq_ready),
    .frequency  (frequency),
    .freq_update(freq_update),
    .range_err  (range_err)
  );

  typedef struct {
    bit          is_err;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] model_freq = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mathematical reference: round-half-up of f * 2^32 / CLK_HZ.
  function automatic logic [31:0] ref_inc(input logic [31:0] f);
    longint unsigned num;
    num = (64'(f) << 32) + 64'(CLK_HZ / 2);
    return 32'(num / 64'(CLK_HZ));
  endfunction

  // Drives one request, holds it until accepted, pushes the expected outcome.
  task automatic send(input logic [31:0] f, input logic [31:0] exp_val, output int c0);
    exp_t e;
    int   n;
    freq_hz    = f;
    freq_valid = 1'b1;
    n = 0;
    while (!freq_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!freq_ready) begin
      check("accept_timeout", 0, 1);
      freq_valid = 1'b0;
      c0 = -1;
      return;
    end
    @(posedge clk);
    #1;
    c0         = cyc;
    freq_valid = 1'b0;
    if (f >= NYQ) begin
      e.is_err = 1'b1;
      e.val    = model_freq;
      e.cyc    = c0;
    end else begin
      e.is_err   = 1'b0;
      e.val      = exp_val;
      e.cyc      = c0 + RES + 1;
      model_freq = exp_val;
    end
    sb.push_back(e);
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (freq_update) begin
        if (sb.size() == 0) begin
          check("unexpected_freq_update", 1, 0);
        end else begin
          e = sb.pop_front();
          check("update_kind", 0, e.is_err);
          check("frequency", frequency, e.val);
          check("update_cycle", cyc, e.cyc);
        end
      end
      if (range_err) begin
        if (sb.size() == 0) begin
          check("unexpected_range_err", 1, 0);
        end else begin
          e = sb.pop_front();
          check("err_kind", 1, e.is_err);
          check("frequency_held", frequency, e.val);
          check("err_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    int          c0, c1;
    logic [31:0] f;
    reset      = 1'b0;
    freq_hz    = '0;
    freq_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_frequency", frequency, 0);
    check("rst_ready", freq_ready, 1);
    check("rst_update", freq_update, 0);
    check("rst_range_err", range_err, 0);
    reset = 1'b1;
    @(negedge clk);

    // Reset in the middle of a conversion abandons it.
    send(32'd10000000, 32'h14D5_5555, c0);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_frequency", frequency, 0);
    check("midrst_ready", freq_ready, 1);
    check("midrst_update", freq_update, 0);
    sb.delete();
    model_freq = 0;
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("midrst_frequency_after", frequency, 0);

    // Directed values.
    send(32'd10000000, 32'h14D5_5555, c0);
    send(32'd1, 32'd35, c0);
    send(32'd0, 32'd0, c0);
    send(32'd61439999, 32'h7FFF_FFDD, c0);
    send(32'd61440000, 32'd0, c0);
    send(32'hFFFF_FFFF, 32'd0, c0);

    // Back-to-back: the second word waits while busy, then is accepted at edge 34.
    send(32'd20000000, ref_inc(32'd20000000), c0);
    send(32'd30000000, ref_inc(32'd30000000), c1);
    check("b2b_accept_edge", c1 - c0, RES + 2);
    send(32'd30000000, ref_inc(32'd30000000), c0);

    // Random sweep, with an occasional out-of-range request mixed in.
    for (int i = 0; i < 1000; i++) begin
      if (i % 50 == 7) begin
        f = NYQ + $urandom_range(0, 100000);
      end else begin
        f = $urandom_range(0, NYQ - 1);
      end
      send(f, ref_inc(f), c0);
    end

    freq_valid = 1'b0;
    repeat (40) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
